// File: rtl/sync_tx_arbiter.sv
// sync_tx_arbiter: round-robin arbiter that launches one word at a time onto a
// toggle-handshake synchronizer bus, enforcing SETUP/HOLD spacing around each flip.
`default_nettype none

module sync_tx_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2,
  parameter int SETUP = 2,
  parameter int HOLD  = 6
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_dat,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      bus_dat,
  output logic [IDW-1:0]        bus_id,
  output logic                  bus_toggle,
  output logic                  busy
);

  localparam int CMAX = (SETUP > HOLD) ? SETUP : HOLD;
  localparam int CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_SETUP = 2'd1;
  localparam logic [1:0] c_ST_HOLD  = 2'd2;

  localparam logic [CNTW-1:0] c_SETUP_LD = CNTW'(SETUP - 1);
  localparam logic [CNTW-1:0] c_HOLD_LD  = CNTW'(HOLD - 1);
  localparam logic [IDW-1:0]  c_LAST_RST = IDW'(NREQ - 1);

  logic [1:0]       state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [WIDTH-1:0] bus_dat_q, bus_dat_d;
  logic [IDW-1:0]   bus_id_q, bus_id_d;
  logic             bus_toggle_q, bus_toggle_d;
  logic             busy_q, busy_d;

  logic             w_any;
  logic             w_grant;
  logic             w_hi_found;
  logic [IDW-1:0]   w_hi;
  logic [IDW-1:0]   w_lo;
  logic [IDW-1:0]   w_win;

  // Round-robin: lowest requester above last wins, otherwise wrap to lowest overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo = IDW'(i);
        if (i > int'(last_q)) begin
          w_hi_found = 1'b1;
          w_hi       = IDW'(i);
        end
      end
    end
    w_any = |req;
    w_win = w_hi_found ? w_hi : w_lo;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= c_ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_grant = 1'b0;
    case (state_q)
      c_ST_IDLE: begin
        if (w_any) w_grant = 1'b1;
      end
      c_ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = c_ST_HOLD;
          cnt_d   = c_HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      c_ST_HOLD: begin
        if (cnt_q == '0) begin
          if (w_any) w_grant = 1'b1;
          else       state_d = c_ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase
    if (w_grant) begin
      state_d = c_ST_SETUP;
      cnt_d   = c_SETUP_LD;
    end
  end

  // Output next-state: every output is the Q of its own flop.
  always_comb begin
    ack_d        = '0;
    bus_dat_d    = bus_dat_q;
    bus_id_d     = bus_id_q;
    bus_toggle_d = bus_toggle_q;
    last_d       = last_q;
    busy_d       = (state_d != c_ST_IDLE);
    if (w_grant) begin
      ack_d[w_win] = 1'b1;
      bus_dat_d    = req_dat[int'(w_win)*WIDTH +: WIDTH];
      bus_id_d     = w_win;
      last_d       = w_win;
    end
    if (state_q == c_ST_SETUP && cnt_q == '0) bus_toggle_d = ~bus_toggle_q;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ack_q        <= '0;
      bus_dat_q    <= '0;
      bus_id_q     <= '0;
      bus_toggle_q <= 1'b0;
      busy_q       <= 1'b0;
      last_q       <= c_LAST_RST;
    end else begin
      ack_q        <= ack_d;
      bus_dat_q    <= bus_dat_d;
      bus_id_q     <= bus_id_d;
      bus_toggle_q <= bus_toggle_d;
      busy_q       <= busy_d;
      last_q       <= last_d;
    end
  end

  assign ack        = ack_q;
  assign bus_dat    = bus_dat_q;
  assign bus_id     = bus_id_q;
  assign bus_toggle = bus_toggle_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_tx_arbiter.sv
// tb_sync_tx_arbiter: directed scenarios plus random traffic against a
// timeline-based reference model of the arbiter.
`default_nettype none

module tb_sync_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;
  localparam int SETUP = 2;
  localparam int HOLD  = 6;

  logic                  clk = 1'b0;
  logic                  arst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_dat = '0;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      bus_dat;
  logic [IDW-1:0]        bus_id;
  logic                  bus_toggle;
  logic                  busy;

  int vectors = 0;
  int miscompares = 0;

  // Model state: a transfer timeline measured in edges since the last grant.
  logic            m_active;
  int              m_since;
  int              m_last;
  logic [15:0]     m_dat;
  logic [1:0]      m_id;
  logic            m_tog;
  logic [3:0]      m_ack;

  sync_tx_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .SETUP(SETUP), .HOLD(HOLD)) dut (
    .clk(clk), .arst(arst), .req(req), .req_dat(req_dat), .ack(ack),
    .bus_dat(bus_dat), .bus_id(bus_id), .bus_toggle(bus_toggle), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_active = 1'b0; m_since = 0; m_last = NREQ - 1;
    m_dat = '0; m_id = '0; m_tog = 1'b0; m_ack = '0;
  endfunction

  function automatic void model_edge();
    int w;
    int idx;
    m_ack = '0;
    if (!m_active || m_since == SETUP + HOLD - 1) begin
      if (req != '0) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_last + k) % NREQ;
          if (w < 0 && req[idx]) w = idx;
        end
        m_ack[w] = 1'b1;
        m_dat    = req_dat[w*WIDTH +: WIDTH];
        m_id     = w[1:0];
        m_last   = w;
        m_active = 1'b1;
        m_since  = 0;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_since++;
      if (m_since == SETUP) m_tog = ~m_tog;
    end
  endfunction

  function automatic logic [23:0] got();
    return {ack, bus_dat, bus_id, bus_toggle, busy};
  endfunction

  function automatic logic [23:0] expv();
    return {m_ack, m_dat, m_id, m_tog, m_active};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (arst) model_reset();
    else      model_edge();
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    req  = '0;
    model_reset();
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  task automatic test_reset();
    req = 4'b1111;
    req_dat = {$urandom, $urandom};
    arst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (got() !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_async: got %h expected %h", got(), 24'h0);
    end
    tick();
    vectors++;
    if (got() !== expv()) begin
      miscompares++;
      $display("FAIL reset_held: got %h expected %h", got(), expv());
    end
    req = '0;
    arst = 1'b0;
    tick();
    vectors++;
    if (got() !== expv()) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", got(), expv());
    end
  endtask

  task automatic test_single();
    do_reset();
    req_dat = {$urandom, $urandom};
    req_dat[1*WIDTH +: WIDTH] = 16'hA5A5;
    req = 4'b0010;
    tick();
    vectors++;
    if (got() !== expv() || bus_dat !== 16'hA5A5 || bus_id !== 2'd1 || ack !== 4'b0010) begin
      miscompares++;
      $display("FAIL single_grant: got %h expected %h", got(), expv());
    end
    req = '0;
    for (int e = 2; e <= 10; e++) begin
      req_dat = {$urandom, $urandom};
      tick();
      vectors++;
      if (got() !== expv() || (e == 2 && bus_toggle !== 1'b0) || (e == 3 && bus_toggle !== 1'b1) ||
          (e == 8 && busy !== 1'b1) || (e == 9 && busy !== 1'b0)) begin
        miscompares++;
        $display("FAIL single_edge%0d: got %h expected %h", e, got(), expv());
      end
    end
  endtask

  task automatic test_saturation();
    int g_edge[$];
    int g_id[$];
    int t_edge[$];
    logic prev_tog;
    int exp_g[5] = '{1, 9, 17, 25, 33};
    int exp_i[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    prev_tog = bus_toggle;
    for (int e = 1; e <= 36; e++) begin
      req_dat = {$urandom, $urandom};
      tick();
      vectors++;
      if (got() !== expv()) begin
        miscompares++;
        $display("FAIL sat_edge%0d: got %h expected %h", e, got(), expv());
      end
      if (ack != '0) begin
        g_edge.push_back(e);
        g_id.push_back(int'(bus_id));
      end
      if (bus_toggle !== prev_tog) t_edge.push_back(e);
      prev_tog = bus_toggle;
    end
    req = '0;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (g_edge.size() <= k || t_edge.size() <= k ||
          g_edge[k] != exp_g[k] || g_id[k] != exp_i[k] || t_edge[k] != exp_g[k] + SETUP) begin
        miscompares++;
        $display("FAIL sat_grant%0d: got %0d grants/%0d flips, expected grant edge %0d id %0d flip %0d",
                 k, g_edge.size(), t_edge.size(), exp_g[k], exp_i[k], exp_g[k] + SETUP);
      end
    end
  endtask

  task automatic test_fairness();
    int ids[$];
    do_reset();
    req_dat = {$urandom, $urandom};
    req = 4'b0100;
    tick();
    vectors++;
    if (got() !== expv() || ack !== 4'b0100) begin
      miscompares++;
      $display("FAIL fair_first: got %h expected %h", got(), expv());
    end
    req = 4'b1100;
    for (int e = 0; e < 20; e++) begin
      req_dat = {$urandom, $urandom};
      tick();
      vectors++;
      if (got() !== expv()) begin
        miscompares++;
        $display("FAIL fair_edge%0d: got %h expected %h", e, got(), expv());
      end
      if (ack != '0) ids.push_back(int'(bus_id));
    end
    req = '0;
    vectors++;
    if (ids.size() < 2 || ids[0] != 3 || ids[1] != 2) begin
      miscompares++;
      $display("FAIL fair_order: got %0d grants first=%0d, expected 3 then 2",
               ids.size(), (ids.size() > 0) ? ids[0] : -1);
    end
  endtask

  task automatic test_withdrawal();
    logic [15:0] word;
    do_reset();
    req_dat = {$urandom, $urandom};
    word = req_dat[1*WIDTH +: WIDTH];
    req = 4'b0010;
    tick();
    req = '0;
    for (int e = 2; e <= 12; e++) begin
      req = (e == 5) ? 4'b0001 : 4'b0000;
      req_dat = {$urandom, $urandom};
      tick();
      vectors++;
      if (got() !== expv() || ack !== '0 || bus_dat !== word || bus_id !== 2'd1 ||
          (e >= 9 && busy !== 1'b0)) begin
        miscompares++;
        $display("FAIL withdraw_edge%0d: got %h expected %h", e, got(), expv());
      end
    end
  endtask

  task automatic test_reset_mid_setup();
    do_reset();
    req_dat = {$urandom, $urandom};
    req = 4'b0001;
    tick();
    tick();
    arst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (got() !== 24'h0) begin
      miscompares++;
      $display("FAIL midsetup_async: got %h expected %h", got(), 24'h0);
    end
    tick();
    vectors++;
    if (got() !== expv() || bus_toggle !== 1'b0) begin
      miscompares++;
      $display("FAIL midsetup_noflip: got %h expected %h", got(), expv());
    end
    arst = 1'b0;
    req = 4'b1001;
    tick();
    vectors++;
    if (got() !== expv() || ack !== 4'b0001 || bus_id !== 2'd0) begin
      miscompares++;
      $display("FAIL midsetup_regrant: got %h expected %h", got(), expv());
    end
    req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (($urandom_range(0, 1) == 0) ? 4'b0000 : req);
      req_dat = {$urandom, $urandom};
      if ($urandom_range(0, 99) == 0) begin
        arst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (got() !== 24'h0) begin
          miscompares++;
          $display("FAIL rand_reset%0d: got %h expected %h", c, got(), 24'h0);
        end
        tick();
        arst = 1'b0;
      end
      tick();
      vectors++;
      if (got() !== expv()) begin
        miscompares++;
        $display("FAIL rand_cyc%0d: got %h expected %h", c, got(), expv());
      end
    end
    req = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_saturation();
    test_fairness();
    test_withdrawal();
    test_reset_mid_setup();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
